// File: rtl/cpu_data_mc.sv
// cpu_data_mc: multi-cycle CPU data path.
// Contents: register file with a memory-mapped port register, wait-stated data
// memory, N_ACC accumulators, an ALU and C/Z/B flags.
// Each instruction is accepted through a START/READY handshake and ends with a DONE pulse.
// Optional feature: define CPU_DATA_OVF_EN to add the signed-overflow flag output V.
module cpu_data_mc #(
    parameter int WIDTH        = 8,
    parameter int REG_SIZE     = 9,
    parameter int REG_SEL_SIZE = 4,
    parameter int N_ACC        = 2,
    parameter int DMEM_DEPTH   = 256,
    parameter int MEM_LAT      = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    output logic                    READY,
    output logic                    DONE,
    input  logic [3:0]              ALU_OP,
    input  logic [1:0]              ACC_SEL,
    input  logic [1:0]              IN_B_SEL,
    input  logic [WIDTH-1:0]        IMM,
    input  logic [REG_SEL_SIZE-1:0] REG_SEL,
    input  logic                    EN_REG_F,
    input  logic                    EN_D_MEM,
    input  logic                    EN_ACC,
    input  logic [WIDTH-1:0]        D_MEM_ADDR,
    input  logic                    D_MEM_ADDR_MODE,
    input  logic [WIDTH-1:0]        PORT_IN,
    output logic [WIDTH-1:0]        PORT_OUT,
    output logic [WIDTH-1:0]        ACC_OUT,
    output logic                    C,
    output logic                    Z,
`ifdef CPU_DATA_OVF_EN
    output logic                    B,
    output logic                    V
`else
    output logic                    B
`endif
);

    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam bit HAS_LAT = (MEM_LAT > 0);
    localparam logic [2:0] LAT_M1 = HAS_LAT ? 3'(MEM_LAT - 1) : 3'd0;
    localparam logic [REG_SEL_SIZE-1:0] PORT_IDX = REG_SEL_SIZE'(REG_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_EXEC, S_WR_WAIT} state_t;

    state_t                  r_state;
    logic [2:0]              r_waitCnt;
    logic                    r_ready, r_done;
    logic [3:0]              r_aluOp;
    logic [1:0]              r_inBSel;
    logic [WIDTH-1:0]        r_imm, r_portIn, r_inA, r_portOut;
    logic [REG_SEL_SIZE-1:0] r_regSel;
    logic                    r_enRegF, r_enDMem, r_enAcc;
    logic [AW-1:0]           r_memAddr;
    logic [1:0]              r_accIdx;
    logic [WIDTH-1:0]        r_acc [N_ACC];
    logic [WIDTH-1:0]        r_regs [REG_SIZE-1];
    logic [WIDTH-1:0]        r_dmem [DMEM_DEPTH];
    logic                    r_c, r_z, r_b;

    logic [1:0]              w_accIdxLive;
    logic [WIDTH-1:0]        w_accLive, w_accOut, w_regRdLive, w_regRdLat, w_addrLive;
    logic [WIDTH-1:0]        w_opB, w_res;
    logic [WIDTH:0]          w_sum;
    logic                    w_cNext, w_bNext, w_memWe;

    // Out-of-range accumulator selects fall back to accumulator 0; pick the live and latched values
    always_comb begin
        w_accIdxLive = (int'(ACC_SEL) < N_ACC) ? ACC_SEL : 2'd0;
        w_accLive    = '0;
        w_accOut     = '0;
        for (int i = 0; i < N_ACC; i++) begin
            if (int'(w_accIdxLive) == i) w_accLive = r_acc[i];
            if (int'(r_accIdx) == i)     w_accOut  = r_acc[i];
        end
    end

    // Register reads: the top index maps to the port input, anything beyond reads as zero
    always_comb begin
        w_regRdLive = (REG_SEL == PORT_IDX) ? PORT_IN : '0;
        w_regRdLat  = (r_regSel == PORT_IDX) ? r_portIn : '0;
        for (int i = 0; i < REG_SIZE - 1; i++) begin
            if (REG_SEL == REG_SEL_SIZE'(i))  w_regRdLive = r_regs[i];
            if (r_regSel == REG_SEL_SIZE'(i)) w_regRdLat  = r_regs[i];
        end
        w_addrLive = D_MEM_ADDR_MODE ? w_regRdLive : D_MEM_ADDR;
    end

    // Operand B mux and ALU; arithmetic runs one bit wider to capture carry/borrow
    always_comb begin
        case (r_inBSel)
            2'd0:    w_opB = r_imm;
            2'd1:    w_opB = w_regRdLat;
            default: w_opB = r_dmem[r_memAddr];
        endcase
        w_sum   = '0;
        w_res   = r_inA;
        w_cNext = r_c;
        w_bNext = r_b;
        case (r_aluOp)
            4'h1: begin w_sum = {1'b0, r_inA} + {1'b0, w_opB}; w_res = w_sum[WIDTH-1:0]; w_cNext = w_sum[WIDTH]; end
            4'h2: begin w_sum = {1'b0, r_inA} + {1'b0, w_opB} + {{WIDTH{1'b0}}, r_c}; w_res = w_sum[WIDTH-1:0]; w_cNext = w_sum[WIDTH]; end
            4'h3: begin w_sum = {1'b0, r_inA} - {1'b0, w_opB}; w_res = w_sum[WIDTH-1:0]; w_bNext = w_sum[WIDTH]; end
            4'h4: begin w_sum = {1'b0, r_inA} - {1'b0, w_opB} - {{WIDTH{1'b0}}, r_b}; w_res = w_sum[WIDTH-1:0]; w_bNext = w_sum[WIDTH]; end
            4'h5: w_res = r_inA & w_opB;
            4'h6: w_res = r_inA | w_opB;
            4'h7: w_res = r_inA ^ w_opB;
            4'h8: w_res = ~r_inA;
            4'h9: w_res = w_opB;
            4'hA: begin w_res = {r_inA[WIDTH-2:0], 1'b0}; w_cNext = r_inA[WIDTH-1]; end
            4'hB: begin w_res = {1'b0, r_inA[WIDTH-1:1]}; w_cNext = r_inA[0]; end
            default: w_res = r_inA;
        endcase
    end

`ifdef CPU_DATA_OVF_EN
    logic r_v, w_vNext;

    // Signed overflow: operands agree in sign (B inverted for subtraction) but the result does not
    always_comb begin
        w_vNext = r_v;
        case (r_aluOp)
            4'h1, 4'h2: w_vNext = (r_inA[WIDTH-1] == w_opB[WIDTH-1]) && (w_res[WIDTH-1] != r_inA[WIDTH-1]);
            4'h3, 4'h4: w_vNext = (r_inA[WIDTH-1] != w_opB[WIDTH-1]) && (w_res[WIDTH-1] != r_inA[WIDTH-1]);
            default:    w_vNext = r_v;
        endcase
    end

    // Overflow flag register, updated only on an accumulator-loading commit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_v <= 1'b0;
        else if (r_state == S_EXEC && r_enAcc) r_v <= w_vNext;
    end

    assign V = r_v;
`endif

    // Memory write fires on the final wait edge, or on the commit edge when there are no wait states
    assign w_memWe = r_enDMem && (HAS_LAT ? (r_state == S_WR_WAIT && r_waitCnt == 3'd0) : (r_state == S_EXEC));

    // Data memory holds its contents through reset; the write is gated by FSM state so reset drops it
    always_ff @(posedge CLK) begin
        if (w_memWe) r_dmem[r_memAddr] <= r_inA;
    end

    // Control FSM plus all architectural state: latches the instruction, then commits ACC/flags/registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_waitCnt <= 3'd0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_aluOp   <= '0;
            r_inBSel  <= '0;
            r_imm     <= '0;
            r_portIn  <= '0;
            r_inA     <= '0;
            r_portOut <= '0;
            r_regSel  <= '0;
            r_enRegF  <= 1'b0;
            r_enDMem  <= 1'b0;
            r_enAcc   <= 1'b0;
            r_memAddr <= '0;
            r_accIdx  <= '0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_b       <= 1'b0;
            for (int i = 0; i < N_ACC; i++) r_acc[i] <= '0;
            for (int i = 0; i < REG_SIZE - 1; i++) r_regs[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_aluOp   <= ALU_OP;
                        r_inBSel  <= IN_B_SEL;
                        r_imm     <= IMM;
                        r_portIn  <= PORT_IN;
                        r_regSel  <= REG_SEL;
                        r_enRegF  <= EN_REG_F;
                        r_enDMem  <= EN_D_MEM;
                        r_enAcc   <= EN_ACC;
                        r_memAddr <= AW'(int'(w_addrLive) % DMEM_DEPTH);
                        r_accIdx  <= w_accIdxLive;
                        r_inA     <= w_accLive;
                        r_ready   <= 1'b0;
                        r_waitCnt <= LAT_M1;
                        r_state   <= (IN_B_SEL[1] && HAS_LAT) ? S_RD_WAIT : S_EXEC;
                    end
                end
                S_RD_WAIT: begin
                    if (r_waitCnt == 3'd0) r_state <= S_EXEC;
                    else r_waitCnt <= r_waitCnt - 3'd1;
                end
                S_EXEC: begin
                    if (r_enAcc) begin
                        for (int i = 0; i < N_ACC; i++)
                            if (int'(r_accIdx) == i) r_acc[i] <= w_res;
                        r_c <= w_cNext;
                        r_b <= w_bNext;
                        r_z <= (w_res == '0);
                    end
                    if (r_enRegF) begin
                        if (r_regSel == PORT_IDX) r_portOut <= r_inA;
                        for (int i = 0; i < REG_SIZE - 1; i++)
                            if (r_regSel == REG_SEL_SIZE'(i)) r_regs[i] <= r_inA;
                    end
                    r_waitCnt <= LAT_M1;
                    if (r_enDMem && HAS_LAT) begin
                        r_state <= S_WR_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                S_WR_WAIT: begin
                    if (r_waitCnt == 3'd0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign READY    = r_ready;
    assign DONE     = r_done;
    assign PORT_OUT = r_portOut;
    assign ACC_OUT  = w_accOut;
    assign C        = r_c;
    assign Z        = r_z;
    assign B        = r_b;

endmodule

// File: tb/tb_cpu_data_mc.sv
// Testbench for cpu_data_mc, built with two memory wait states.
// The main check is a table of instructions with hand-computed results.
// After the table come directed sequences for a START while busy and a reset during a pending write.
module tb_cpu_data_mc;

   localparam int LAT = 2;

   logic       CLK, RST_N, START;
   logic       READY, DONE;
   logic [3:0] ALU_OP;
   logic [1:0] ACC_SEL, IN_B_SEL;
   logic [7:0] IMM, D_MEM_ADDR, PORT_IN, PORT_OUT, ACC_OUT;
   logic [3:0] REG_SEL;
   logic       EN_REG_F, EN_D_MEM, EN_ACC, D_MEM_ADDR_MODE;
   logic       C, Z, B;
`ifdef CPU_DATA_OVF_EN
   logic       V;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] op;
      logic [1:0] accSel;
      logic [1:0] bSel;
      logic [7:0] imm;
      logic [3:0] regSel;
      logic       enRegF, enDMem, enAcc;
      logic [7:0] addr;
      logic       addrMode;
      logic [7:0] portIn;
      logic [7:0] expAcc;
      logic       expC, expZ, expB;
      logic [7:0] expPort;
      int         expLat;
   } vec_t;

   vec_t vecs[$];

   cpu_data_mc #(
      .WIDTH(8), .REG_SIZE(9), .REG_SEL_SIZE(4), .N_ACC(2), .DMEM_DEPTH(256), .MEM_LAT(LAT)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .READY(READY), .DONE(DONE),
      .ALU_OP(ALU_OP), .ACC_SEL(ACC_SEL), .IN_B_SEL(IN_B_SEL), .IMM(IMM), .REG_SEL(REG_SEL),
      .EN_REG_F(EN_REG_F), .EN_D_MEM(EN_D_MEM), .EN_ACC(EN_ACC), .D_MEM_ADDR(D_MEM_ADDR),
      .D_MEM_ADDR_MODE(D_MEM_ADDR_MODE), .PORT_IN(PORT_IN), .PORT_OUT(PORT_OUT),
      .ACC_OUT(ACC_OUT), .C(C), .Z(Z),
`ifdef CPU_DATA_OVF_EN
      .B(B), .V(V)
`else
      .B(B)
`endif
   );

   // Free-running 10-unit clock
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic vec_t mk(input logic [3:0] op, input logic [1:0] accSel, input logic [1:0] bSel,
                               input logic [7:0] imm, input logic [3:0] regSel, input logic enRegF,
                               input logic enDMem, input logic enAcc, input logic [7:0] addr,
                               input logic addrMode, input logic [7:0] portIn, input logic [7:0] expAcc,
                               input logic expC, input logic expZ, input logic expB,
                               input logic [7:0] expPort, input int expLat);
      vec_t v;
      v.op = op; v.accSel = accSel; v.bSel = bSel; v.imm = imm; v.regSel = regSel;
      v.enRegF = enRegF; v.enDMem = enDMem; v.enAcc = enAcc; v.addr = addr;
      v.addrMode = addrMode; v.portIn = portIn; v.expAcc = expAcc; v.expC = expC;
      v.expZ = expZ; v.expB = expB; v.expPort = expPort; v.expLat = expLat;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic driveInputs(input vec_t v);
      ALU_OP = v.op; ACC_SEL = v.accSel; IN_B_SEL = v.bSel; IMM = v.imm; REG_SEL = v.regSel;
      EN_REG_F = v.enRegF; EN_D_MEM = v.enDMem; EN_ACC = v.enAcc; D_MEM_ADDR = v.addr;
      D_MEM_ADDR_MODE = v.addrMode; PORT_IN = v.portIn;
   endtask

   task automatic scribbleInputs();
      ALU_OP = 4'h7; ACC_SEL = 2'd1; IN_B_SEL = 2'd1; IMM = 8'hEE; REG_SEL = 4'd5;
      EN_REG_F = 1'b1; EN_D_MEM = 1'b1; EN_ACC = 1'b0; D_MEM_ADDR = 8'hEE;
      D_MEM_ADDR_MODE = 1'b1; PORT_IN = 8'hEE;
   endtask

   // Issue one instruction from a negedge; return edges from START to the DONE cycle (-1 on timeout)
   task automatic applyStimulus(input vec_t v, output int lat);
      int n = 0;
      while (!READY && n < 50) begin @(negedge CLK); n++; end
      driveInputs(v);
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      scribbleInputs();
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (DONE) begin lat = k; break; end
      end
   endtask

   task automatic runVec(input string tag, input vec_t v);
      int lat;
      applyStimulus(v, lat);
      checkOutput({tag, " latency"}, lat, v.expLat);
      checkOutput({tag, " acc"},     ACC_OUT, v.expAcc);
      checkOutput({tag, " C"},       C, v.expC);
      checkOutput({tag, " Z"},       Z, v.expZ);
      checkOutput({tag, " B"},       B, v.expB);
      checkOutput({tag, " port"},    PORT_OUT, v.expPort);
   endtask

   // Safety net so the bench always ends
   initial begin
      #200000;
      $display("[TB] FAIL global timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int doneCount;
      vec_t v;

      // op accSel bSel imm regSel enRegF enDMem enAcc addr mode portIn | acc C Z B port lat
      vecs.push_back(mk(4'h9, 2'd1, 2'd0, 8'h3C, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h3C, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(4'h0, 2'd0, 2'd0, 8'h00, 4'd0,  0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(4'h9, 2'd0, 2'd0, 8'hF0, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'hF0, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(4'h1, 2'd0, 2'd0, 8'h20, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h10, 1, 0, 0, 8'h00, 1));
      vecs.push_back(mk(4'h2, 2'd0, 2'd0, 8'h00, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h11, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(4'h9, 2'd0, 2'd0, 8'h55, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h55, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(4'h0, 2'd0, 2'd0, 8'h00, 4'd0,  0, 1, 0, 8'h0A, 0, 8'h00, 8'h55, 0, 0, 0, 8'h00, 1 + LAT));
      vecs.push_back(mk(4'h9, 2'd0, 2'd0, 8'h00, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 1));
      vecs.push_back(mk(4'h9, 2'd0, 2'd2, 8'h00, 4'd0,  0, 0, 1, 8'h0A, 0, 8'h00, 8'h55, 0, 0, 0, 8'h00, 1 + LAT));
      vecs.push_back(mk(4'h9, 2'd0, 2'd0, 8'h0A, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h0A, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(4'h0, 2'd0, 2'd0, 8'h00, 4'd2,  1, 0, 0, 8'h00, 0, 8'h00, 8'h0A, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(4'h9, 2'd0, 2'd3, 8'h00, 4'd2,  0, 0, 1, 8'hFF, 1, 8'h00, 8'h55, 0, 0, 0, 8'h00, 1 + LAT));
      vecs.push_back(mk(4'h9, 2'd0, 2'd0, 8'h00, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 1));
      vecs.push_back(mk(4'h3, 2'd0, 2'd0, 8'h01, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 1, 8'h00, 1));
      vecs.push_back(mk(4'h4, 2'd0, 2'd0, 8'h00, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'hFE, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(4'h9, 2'd0, 2'd0, 8'hA5, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'hA5, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(4'h0, 2'd0, 2'd0, 8'h00, 4'd8,  1, 0, 0, 8'h00, 0, 8'h00, 8'hA5, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h9, 2'd0, 2'd1, 8'h00, 4'd8,  0, 0, 1, 8'h00, 0, 8'h33, 8'h33, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h0, 2'd0, 2'd0, 8'h00, 4'd12, 1, 0, 0, 8'h00, 0, 8'h00, 8'h33, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h9, 2'd0, 2'd1, 8'h00, 4'd12, 0, 0, 1, 8'h00, 0, 8'h33, 8'h00, 0, 1, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h1, 2'd1, 2'd0, 8'hC4, 4'd3,  1, 1, 1, 8'h20, 0, 8'h00, 8'h00, 1, 1, 0, 8'hA5, 1 + LAT));
      vecs.push_back(mk(4'h9, 2'd3, 2'd1, 8'h00, 4'd3,  0, 0, 1, 8'h00, 0, 8'h00, 8'h3C, 1, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h9, 2'd1, 2'd2, 8'h00, 4'd0,  0, 1, 1, 8'h20, 0, 8'h00, 8'h3C, 1, 0, 0, 8'hA5, 1 + 2 * LAT));
      vecs.push_back(mk(4'hA, 2'd0, 2'd0, 8'h00, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h78, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h8, 2'd0, 2'd0, 8'h00, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h87, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'hA, 2'd0, 2'd0, 8'h00, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h0E, 1, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'hB, 2'd0, 2'd0, 8'h00, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h07, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h7, 2'd0, 2'd0, 8'h07, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h6, 2'd0, 2'd0, 8'h81, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h81, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h0, 2'd0, 2'd0, 8'h12, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h81, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'hF, 2'd0, 2'd0, 8'h12, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h81, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h3, 2'd0, 2'd0, 8'h82, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 1, 8'hA5, 1));
      vecs.push_back(mk(4'h4, 2'd0, 2'd0, 8'h7F, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h7F, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h5, 2'd0, 2'd0, 8'hF0, 4'd0,  0, 0, 1, 8'h00, 0, 8'h00, 8'h70, 0, 0, 0, 8'hA5, 1));
      vecs.push_back(mk(4'h9, 2'd1, 2'd2, 8'h00, 4'd0,  0, 0, 1, 8'h20, 0, 8'h00, 8'h00, 0, 1, 0, 8'hA5, 1 + LAT));

      RST_N = 1'b0;
      START = 1'b0;
      scribbleInputs();
      repeat (3) @(negedge CLK);
      checkOutput("reset ready", READY, 1);
      checkOutput("reset done",  DONE, 0);
      checkOutput("reset acc",   ACC_OUT, 0);
      checkOutput("reset flags", {C, Z, B}, 0);
      checkOutput("reset port",  PORT_OUT, 0);
      RST_N = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < vecs.size(); i++) runVec($sformatf("v%0d", i), vecs[i]);

      // START held high through the busy cycle must not launch a second instruction
      v = mk(4'h9, 2'd0, 2'd0, 8'h11, 4'd0, 0, 0, 1, 8'h00, 0, 8'h00, 8'h11, 0, 0, 0, 8'hA5, 1);
      driveInputs(v);
      START = 1'b1;
      @(posedge CLK);
      #1;
      IMM = 8'h99;
      @(negedge CLK);
      checkOutput("busy ready low", READY, 0);
      @(posedge CLK);
      #1;
      START = 1'b0;
      @(negedge CLK);
      checkOutput("busy done", DONE, 1);
      checkOutput("busy acc", ACC_OUT, 8'h11);
      doneCount = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         if (DONE) doneCount++;
      end
      checkOutput("busy extra done", doneCount, 0);
      checkOutput("busy acc hold", ACC_OUT, 8'h11);

      // Reset during a pending memory write: state clears, memory keeps the old word
      runVec("rs store", mk(4'h0, 2'd0, 2'd0, 8'h00, 4'd0, 0, 1, 0, 8'h30, 0, 8'h00, 8'h11, 0, 0, 0, 8'hA5, 1 + LAT));
      runVec("rs load",  mk(4'h9, 2'd0, 2'd0, 8'hF0, 4'd0, 0, 0, 1, 8'h00, 0, 8'h00, 8'hF0, 0, 0, 0, 8'hA5, 1));
      runVec("rs add",   mk(4'h1, 2'd0, 2'd0, 8'h87, 4'd0, 0, 0, 1, 8'h00, 0, 8'h00, 8'h77, 1, 0, 0, 8'hA5, 1));
      driveInputs(mk(4'h0, 2'd0, 2'd0, 8'h00, 4'd0, 0, 1, 0, 8'h30, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      checkOutput("wr reset ready", READY, 1);
      checkOutput("wr reset done",  DONE, 0);
      checkOutput("wr reset acc",   ACC_OUT, 0);
      checkOutput("wr reset flags", {C, Z, B}, 0);
      checkOutput("wr reset port",  PORT_OUT, 0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      runVec("rs acc1",  mk(4'h0, 2'd1, 2'd0, 8'h00, 4'd0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1));
      runVec("rs mem",   mk(4'h9, 2'd0, 2'd2, 8'h00, 4'd0, 0, 0, 1, 8'h30, 0, 8'h00, 8'h11, 0, 0, 0, 8'h00, 1 + LAT));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
